// File: rtl/ucdp_fifo_flex.sv
// ucdp_fifo_flex -- single-clock FIFO with arbitrary depth.
//
// Show-ahead FIFO: data_o presents the oldest stored word while empty_o is low.
// Pointers wrap by explicit compare, so depth_p need not be a power of two.
//
// Ports
//   main_clk_i, main_rst_an_i  clock (rising edge), async active-low reset
//   dft_mode_*_i               test control, no functional effect
//   flush_i                    synchronous clear of contents (highest priority)
//   wr_ena_i, data_i           write request / write data
//   rd_ena_i                   read request (pop)
//   data_o                     head-of-FIFO word
//   empty_o, full_o            fill status
//   almost_empty_o             filling <= aempty_thr_p
//   almost_full_o              filling >= afull_thr_p
//   filling_o                  number of stored entries
//   overflow_o, underflow_o    sticky error flags, cleared by err_clr_i
module ucdp_fifo_flex #(
  parameter int unsigned width_p         = 8,
  parameter int unsigned depth_p         = 8,
  parameter int unsigned afull_thr_p     = depth_p - 1,
  parameter int unsigned aempty_thr_p    = 1,
  parameter int unsigned out_reg_p       = 0,
  parameter int unsigned filling_width_p = $clog2(depth_p + 1)
) (
  input  logic                       main_clk_i,
  input  logic                       main_rst_an_i,
  input  logic                       dft_mode_test_mode_i,
  input  logic                       dft_mode_scan_mode_i,
  input  logic                       dft_mode_scan_shift_i,
  input  logic                       dft_mode_mbist_mode_i,
  input  logic                       flush_i,
  input  logic                       wr_ena_i,
  input  logic [width_p-1:0]         data_i,
  input  logic                       rd_ena_i,
  output logic [width_p-1:0]         data_o,
  output logic                       empty_o,
  output logic                       full_o,
  output logic                       almost_empty_o,
  output logic                       almost_full_o,
  output logic [filling_width_p-1:0] filling_o,
  output logic                       overflow_o,
  output logic                       underflow_o,
  input  logic                       err_clr_i
);

  localparam int unsigned PtrWidthC = $clog2(depth_p);

  localparam logic [PtrWidthC-1:0]       PtrLastC  = PtrWidthC'(depth_p - 1);
  localparam logic [PtrWidthC-1:0]       PtrOneC   = PtrWidthC'(1);
  localparam logic [filling_width_p-1:0] FillOneC  = filling_width_p'(1);
  localparam logic [filling_width_p-1:0] FillFullC = filling_width_p'(depth_p);
  localparam logic [filling_width_p-1:0] AFullC    = filling_width_p'(afull_thr_p);
  localparam logic [filling_width_p-1:0] AEmptyC   = filling_width_p'(aempty_thr_p);

  logic [width_p-1:0]         mem_q [depth_p];
  logic [PtrWidthC-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PtrWidthC-1:0]       rd_ptr_q, rd_ptr_d;
  logic [filling_width_p-1:0] filling_q, filling_d;
  logic                       overflow_q, overflow_d;
  logic                       underflow_q, underflow_d;
  logic                       empty_s, full_s, rd_s, wr_s;

  logic unused_dft_s;
  assign unused_dft_s = ^{dft_mode_test_mode_i, dft_mode_scan_mode_i,
                          dft_mode_scan_shift_i, dft_mode_mbist_mode_i};

  function automatic logic [PtrWidthC-1:0] ptr_inc(input logic [PtrWidthC-1:0] p);
    return (p == PtrLastC) ? '0 : p + PtrOneC;
  endfunction

  assign empty_s = (filling_q == '0);
  assign full_s  = (filling_q == FillFullC);

  // A read frees a slot in the same cycle, so a full FIFO still accepts a
  // write alongside an accepted read.
  assign rd_s = rd_ena_i & ~empty_s;
  assign wr_s = wr_ena_i & (~full_s | rd_s);

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    filling_d   = filling_q;
    overflow_d  = overflow_q & ~err_clr_i;
    underflow_d = underflow_q & ~err_clr_i;
    if (flush_i) begin
      wr_ptr_d  = '0;
      rd_ptr_d  = '0;
      filling_d = '0;
    end else begin
      if (wr_s) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (rd_s) rd_ptr_d = ptr_inc(rd_ptr_q);
      if (wr_s & ~rd_s)      filling_d = filling_q + FillOneC;
      else if (rd_s & ~wr_s) filling_d = filling_q - FillOneC;
      // Set wins over a same-cycle clear.
      if (wr_ena_i & ~wr_s) overflow_d  = 1'b1;
      if (rd_ena_i & ~rd_s) underflow_d = 1'b1;
    end
  end

  always_ff @(posedge main_clk_i or negedge main_rst_an_i) begin
    if (!main_rst_an_i) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      filling_q   <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      filling_q   <= filling_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  always_ff @(posedge main_clk_i) begin
    if (wr_s & ~flush_i) mem_q[wr_ptr_q] <= data_i;
  end

  if (out_reg_p != 0) begin : g_oreg
    logic [width_p-1:0] dout_q, dout_d;
    logic               head_wr_s;

    // The incoming word becomes the head when the FIFO is (or is about to be)
    // empty; otherwise a pop pre-fetches the entry behind the current head.
    assign head_wr_s = wr_s & (empty_s | ((filling_q == FillOneC) & rd_s));

    always_comb begin
      dout_d = dout_q;
      if (!flush_i) begin
        if (head_wr_s) dout_d = data_i;
        else if (rd_s) dout_d = mem_q[ptr_inc(rd_ptr_q)];
      end
    end

    always_ff @(posedge main_clk_i or negedge main_rst_an_i) begin
      if (!main_rst_an_i) dout_q <= '0;
      else                dout_q <= dout_d;
    end

    assign data_o = dout_q;
  end else begin : g_comb
    assign data_o = mem_q[rd_ptr_q];
  end

  assign empty_o        = empty_s;
  assign full_o         = full_s;
  assign almost_full_o  = (filling_q >= AFullC);
  assign almost_empty_o = (filling_q <= AEmptyC);
  assign filling_o      = filling_q;
  assign overflow_o     = overflow_q;
  assign underflow_o    = underflow_q;

endmodule

// File: tb/tb_ucdp_fifo_flex.sv
// Testbench for ucdp_fifo_flex: two depth-5 instances (combinational and
// registered read data) driven in lockstep against a queue-based model.
module tb_ucdp_fifo_flex;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       flush = 1'b0, wr_ena = 1'b0, rd_ena = 1'b0, err_clr = 1'b0;
  logic [7:0] din = '0;
  logic [7:0] dout0, dout1;
  logic       empty0, full0, ae0, af0, ovf0, udf0;
  logic       empty1, full1, ae1, af1, ovf1, udf1;
  logic [2:0] fill0, fill1;

  int checks = 0;
  int passes = 0;

  // Reference model
  logic [7:0] q[$];
  bit         m_ovf, m_udf;

  always #5 clk = ~clk;

  ucdp_fifo_flex #(.width_p(8), .depth_p(5), .afull_thr_p(4), .aempty_thr_p(1), .out_reg_p(0)) dut0 (
    .main_clk_i(clk), .main_rst_an_i(rst_n),
    .dft_mode_test_mode_i(1'b0), .dft_mode_scan_mode_i(1'b0),
    .dft_mode_scan_shift_i(1'b0), .dft_mode_mbist_mode_i(1'b0),
    .flush_i(flush), .wr_ena_i(wr_ena), .data_i(din), .rd_ena_i(rd_ena),
    .data_o(dout0), .empty_o(empty0), .full_o(full0),
    .almost_empty_o(ae0), .almost_full_o(af0), .filling_o(fill0),
    .overflow_o(ovf0), .underflow_o(udf0), .err_clr_i(err_clr));

  ucdp_fifo_flex #(.width_p(8), .depth_p(5), .afull_thr_p(4), .aempty_thr_p(1), .out_reg_p(1)) dut1 (
    .main_clk_i(clk), .main_rst_an_i(rst_n),
    .dft_mode_test_mode_i(1'b0), .dft_mode_scan_mode_i(1'b0),
    .dft_mode_scan_shift_i(1'b0), .dft_mode_mbist_mode_i(1'b0),
    .flush_i(flush), .wr_ena_i(wr_ena), .data_i(din), .rd_ena_i(rd_ena),
    .data_o(dout1), .empty_o(empty1), .full_o(full1),
    .almost_empty_o(ae1), .almost_full_o(af1), .filling_o(fill1),
    .overflow_o(ovf1), .underflow_o(udf1), .err_clr_i(err_clr));

  // Status packed as {empty, full, almost_empty, almost_full, overflow, underflow, filling}
  logic [8:0] st0, st1;
  assign st0 = {empty0, full0, ae0, af0, ovf0, udf0, fill0};
  assign st1 = {empty1, full1, ae1, af1, ovf1, udf1, fill1};

  function automatic logic [8:0] exp_status();
    int n = q.size();
    return {n == 0, n == 5, n <= 1, n >= 4, m_ovf, m_udf, 3'(n)};
  endfunction

  function automatic void model_step(bit wr, bit rd, logic [7:0] d, bit fl, bit clr);
    bit rd_ok, wr_ok;
    if (clr) begin m_ovf = 0; m_udf = 0; end
    if (fl) begin
      q.delete();
      return;
    end
    rd_ok = rd && q.size() > 0;
    wr_ok = wr && (q.size() < 5 || rd_ok);
    if (rd_ok) void'(q.pop_front());
    if (wr_ok) q.push_back(d);
    if (wr && !wr_ok) m_ovf = 1;
    if (rd && !rd_ok) m_udf = 1;
  endfunction

  task automatic step(input bit wr, input bit rd, input logic [7:0] d, input bit fl, input bit clr);
    wr_ena = wr; rd_ena = rd; din = d; flush = fl; err_clr = clr;
    @(posedge clk);
    model_step(wr, rd, d, fl, clr);
    #1;
    wr_ena = 0; rd_ena = 0; flush = 0; err_clr = 0;
  endtask

  task automatic test_reset();
    rst_n = 0;
    #13;
    checks++;
    if ({st0, st1} !== {9'b1_0_1_0_0_0_000, 9'b1_0_1_0_0_0_000})
      $display("FAIL reset_status got %b/%b expected %b", st0, st1, 9'b1_0_1_0_0_0_000);
    else passes++;
    checks++;
    if (dout1 !== 8'h00) $display("FAIL reset_dout1 got %h expected 00", dout1);
    else passes++;
    @(negedge clk);
    rst_n = 1;
    q.delete(); m_ovf = 0; m_udf = 0;
  endtask

  task automatic test_fill_drain();
    logic [7:0] exp_d;
    for (int i = 0; i < 5; i++) begin
      step(1, 0, 8'h11 + 8'(i), 0, 0);
      checks++;
      if (fill0 !== 3'(i + 1) || af0 !== (i >= 3) || full0 !== (i == 4) || st1 !== st0)
        $display("FAIL fill_%0d got fill=%0d af=%b full=%b st1=%b expected fill=%0d af=%b full=%b",
                 i, fill0, af0, full0, st1, i + 1, i >= 3, i == 4);
      else passes++;
    end
    for (int i = 0; i < 5; i++) begin
      exp_d = 8'h11 + 8'(i);
      checks++;
      if (dout0 !== exp_d || dout1 !== exp_d)
        $display("FAIL drain_data_%0d got %h/%h expected %h", i, dout0, dout1, exp_d);
      else passes++;
      step(0, 1, 8'h00, 0, 0);
    end
    checks++;
    if (empty0 !== 1'b1 || empty1 !== 1'b1 || st0 !== exp_status())
      $display("FAIL drain_empty got %b/%b expected %b", st0, st1, exp_status());
    else passes++;
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 5; i++) step(1, 0, 8'h40 + 8'(i), 0, 0);
    step(1, 0, 8'hEE, 0, 0);
    checks++;
    if (ovf0 !== 1'b1 || ovf1 !== 1'b1 || fill0 !== 3'd5 || dout0 !== 8'h40 || dout1 !== 8'h40)
      $display("FAIL overflow_set got ovf=%b/%b fill=%0d head=%h/%h expected ovf=1 fill=5 head=40",
               ovf0, ovf1, fill0, dout0, dout1);
    else passes++;
    step(1, 1, 8'hAA, 0, 0);
    checks++;
    if (st0 !== exp_status() || st1 !== exp_status() || fill0 !== 3'd5 || dout0 !== 8'h41 || dout1 !== 8'h41)
      $display("FAIL passthrough got st=%b/%b head=%h/%h expected st=%b head=41",
               st0, st1, dout0, dout1, exp_status());
    else passes++;
    step(0, 0, 8'h00, 0, 1);
    checks++;
    if (ovf0 !== 1'b0 || ovf1 !== 1'b0) $display("FAIL overflow_clr got %b/%b expected 0", ovf0, ovf1);
    else passes++;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (dout0 !== q[0] || dout1 !== q[0])
        $display("FAIL ovf_drain_%0d got %h/%h expected %h", i, dout0, dout1, q[0]);
      else passes++;
      step(0, 1, 8'h00, 0, 0);
    end
    checks++;
    if (st0 !== exp_status() || st1 !== exp_status())
      $display("FAIL ovf_drained got %b/%b expected %b", st0, st1, exp_status());
    else passes++;
  endtask

  task automatic test_underflow();
    step(1, 1, 8'h3C, 0, 0);
    checks++;
    if (udf0 !== 1'b1 || udf1 !== 1'b1 || fill0 !== 3'd1 || dout0 !== 8'h3C || dout1 !== 8'h3C)
      $display("FAIL underflow got udf=%b/%b fill=%0d data=%h/%h expected udf=1 fill=1 data=3c",
               udf0, udf1, fill0, dout0, dout1);
    else passes++;
    step(0, 0, 8'h00, 0, 1);
    checks++;
    if (udf0 !== 1'b0 || udf1 !== 1'b0 || st0 !== exp_status())
      $display("FAIL underflow_clr got %b/%b expected %b", st0, st1, exp_status());
    else passes++;
    step(0, 1, 8'h00, 0, 0);
  endtask

  task automatic test_flush();
    for (int i = 0; i < 3; i++) step(1, 0, 8'h60 + 8'(i), 0, 0);
    step(1, 1, 8'h99, 1, 0);
    checks++;
    if (st0 !== 9'b1_0_1_0_0_0_000 || st1 !== 9'b1_0_1_0_0_0_000)
      $display("FAIL flush got %b/%b expected %b", st0, st1, 9'b1_0_1_0_0_0_000);
    else passes++;
    step(1, 0, 8'h77, 0, 0);
    checks++;
    if (dout0 !== 8'h77 || dout1 !== 8'h77 || fill0 !== 3'd1)
      $display("FAIL flush_next_write got %h/%h fill=%0d expected 77 fill=1", dout0, dout1, fill0);
    else passes++;
    step(0, 1, 8'h00, 0, 0);
  endtask

  task automatic test_random();
    bit wr, rd, fl, clr;
    logic [7:0] d;
    for (int i = 0; i < 200; i++) begin
      wr  = 1'($urandom_range(0, 1));
      rd  = 1'($urandom_range(0, 1));
      fl  = ($urandom_range(0, 31) == 0);
      clr = ($urandom_range(0, 15) == 0);
      d   = 8'($urandom);
      step(wr, rd, d, fl, clr);
      checks++;
      if (st0 !== exp_status() || st1 !== exp_status())
        $display("FAIL rand_status_%0d got %b/%b expected %b", i, st0, st1, exp_status());
      else passes++;
      if (q.size() > 0) begin
        checks++;
        if (dout0 !== q[0] || dout1 !== q[0])
          $display("FAIL rand_data_%0d got %h/%h expected %h", i, dout0, dout1, q[0]);
        else passes++;
      end
    end
  endtask

  task automatic test_midstream_reset();
    step(0, 0, 8'h00, 1, 1);
    for (int i = 0; i < 3; i++) step(1, 0, 8'h20 + 8'(i), 0, 0);
    step(0, 1, 8'h00, 0, 0);
    step(0, 1, 8'h00, 0, 0);
    step(0, 1, 8'h00, 0, 0);
    step(0, 1, 8'h00, 0, 0);
    for (int i = 0; i < 3; i++) step(1, 0, 8'h30 + 8'(i), 0, 0);
    #2;
    rst_n = 0;
    #1;
    checks++;
    if (st0 !== 9'b1_0_1_0_0_0_000 || st1 !== 9'b1_0_1_0_0_0_000 || dout1 !== 8'h00)
      $display("FAIL async_reset got %b/%b dout1=%h expected %b dout1=00",
               st0, st1, dout1, 9'b1_0_1_0_0_0_000);
    else passes++;
    q.delete(); m_ovf = 0; m_udf = 0;
    @(negedge clk);
    rst_n = 1;
    step(1, 0, 8'h5A, 0, 0);
    checks++;
    if (dout0 !== 8'h5A || dout1 !== 8'h5A || st0 !== exp_status())
      $display("FAIL post_reset_write got %h/%h st=%b expected 5a st=%b",
               dout0, dout1, st0, exp_status());
    else passes++;
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_overflow();
    test_underflow();
    test_flush();
    test_random();
    test_midstream_reset();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
